// File: rtl/dac_stream_pkg.sv
// Shared definitions for the DAC streaming path: sample width and playback FSM states.
package dac_stream_pkg;

  localparam int SAMPLE_WIDTH = 16;

  // Number of beats the output stage can hold at once.
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FLUSH
  } PlayState;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream output stage. Entry 0 drives the stream directly; entry 1 absorbs
// a beat that arrives while entry 0 is stalled. Data registers are zeroed whenever their
// entry is empty, so the stream shows tdata=0 while idle. flush_i discards everything,
// including a push arriving in the same cycle.
module axis_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             aresetn,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       count_o
);

  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic             pop;

  assign pop     = valid0_q & ready_i;
  assign valid_o = valid0_q;
  assign data_o  = data0_q;
  assign count_o = {1'b0, valid0_q} + {1'b0, valid1_q};

  // Pop first (entry 1 moves forward), then place a new beat in the first free entry.
  always_comb begin
    valid0_d = valid0_q;
    valid1_d = valid1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    if (pop) begin
      valid0_d = valid1_q;
      data0_d  = valid1_q ? data1_q : '0;
      valid1_d = 1'b0;
      data1_d  = '0;
    end
    if (push_i) begin
      if (!valid0_d) begin
        valid0_d = 1'b1;
        data0_d  = pushData_i;
      end else begin
        valid1_d = 1'b1;
        data1_d  = pushData_i;
      end
    end
    if (flush_i) begin
      valid0_d = 1'b0;
      valid1_d = 1'b0;
      data0_d  = '0;
      data1_d  = '0;
    end
  end

  // Entry registers.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      valid0_q <= valid0_d;
      valid1_q <= valid1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

endmodule

// File: rtl/dac_waveform_player.sv
// Plays a stored waveform into an RF-DAC AXI4-Stream port, one-shot or looped.
// Waveform RAM (1-cycle, read-first) feeds a two-entry skid buffer; reads are only
// issued when the buffer is guaranteed to have room, so tready never backs up into the RAM.
module dac_waveform_player
  import dac_stream_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                                   clock,
  input  logic                                   aresetn,
  input  logic                                   wr_en,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  input  logic [SAMPLE_WIDTH*NUMBER_OF_LINE-1:0] wr_data,
  input  logic                                   start,
  input  logic                                   stop,
  input  logic                                   loop_enable,
  input  logic [ADDR_WIDTH-1:0]                  play_last,
  output logic                                   busy,
  output logic                                   done,
  output logic [15:0]                            pass_count,
  output logic                                   dac_out_tvalid,
  output logic [SAMPLE_WIDTH*NUMBER_OF_LINE-1:0] dac_out_tdata,
  input  logic                                   dac_out_tready
);

  localparam int DATA_W = SAMPLE_WIDTH * NUMBER_OF_LINE;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  PlayState              state_q, state_d;
  logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
  logic [ADDR_WIDTH-1:0] playLast_q, playLast_d;
  logic                  loopEn_q, loopEn_d;
  logic [ADDR_WIDTH-1:0] outIdx_q, outIdx_d;
  logic [15:0]           passCount_q, passCount_d;
  logic                  done_q, done_d;
  logic                  rdValid_q;
  logic [DATA_W-1:0]     readData_q;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  rdEn;
  logic                  pushEn;
  logic                  flushEn;
  logic                  pop;
  logic                  lastBeatPop;
  logic                  stopNow;
  logic                  canIssue;
  logic [1:0]            skidCount;
  logic [2:0]            occupancy;

  assign pop         = dac_out_tvalid & dac_out_tready;
  assign lastBeatPop = pop && (outIdx_q == playLast_q);
  // With a beat already held, a stop can only discard once that beat has handshaken.
  assign stopNow     = !dac_out_tvalid || pop;
  // Slots that will be taken next cycle: buffered beats, plus the read in flight, minus the
  // beat leaving now. Counting the leaving beat is what allows one beat per cycle.
  assign occupancy   = {1'b0, skidCount} + {2'b00, rdValid_q} - {2'b00, pop};
  assign canIssue    = occupancy < 3'(SKID_DEPTH);
  // Beats still arriving from the RAM after a stop are dropped.
  assign pushEn      = rdValid_q && (state_q != FLUSH);

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign pass_count = passCount_q;

  // Waveform RAM: writes always accepted; nonblocking read gives read-first behaviour.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rdEn) begin
      readData_q <= mem[rdAddr_q];
    end
  end

  // Playback FSM, read issue, output beat tracking and pass counting.
  always_comb begin
    state_d     = state_q;
    rdAddr_d    = rdAddr_q;
    playLast_d  = playLast_q;
    loopEn_d    = loopEn_q;
    outIdx_d    = outIdx_q;
    passCount_d = passCount_q;
    done_d      = 1'b0;
    rdEn        = 1'b0;
    flushEn     = 1'b0;

    if (pop) begin
      if (outIdx_q == playLast_q) begin
        outIdx_d    = '0;
        passCount_d = passCount_q + 16'd1;
      end else begin
        outIdx_d = outIdx_q + ADDR_WIDTH'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          playLast_d  = play_last;
          loopEn_d    = loop_enable;
          rdAddr_d    = '0;
          outIdx_d    = '0;
          passCount_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = FLUSH;
          flushEn = stopNow;
        end else if (canIssue) begin
          rdEn = 1'b1;
          if (rdAddr_q == playLast_q) begin
            rdAddr_d = '0;
            if (!loopEn_q) begin
              state_d = DRAIN;
            end
          end else begin
            rdAddr_d = rdAddr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (stop) begin
          state_d = FLUSH;
          flushEn = stopNow;
        end else if (lastBeatPop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      FLUSH: begin
        if (stopNow) begin
          flushEn = 1'b1;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clock or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      rdAddr_q    <= '0;
      playLast_q  <= '0;
      loopEn_q    <= 1'b0;
      outIdx_q    <= '0;
      passCount_q <= '0;
      done_q      <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdAddr_q    <= rdAddr_d;
      playLast_q  <= playLast_d;
      loopEn_q    <= loopEn_d;
      outIdx_q    <= outIdx_d;
      passCount_q <= passCount_d;
      done_q      <= done_d;
      rdValid_q   <= rdEn;
    end
  end

  axis_skid_buffer #(
    .WIDTH(DATA_W)
  ) outStage (
    .clock     (clock),
    .aresetn   (aresetn),
    .flush_i   (flushEn),
    .push_i    (pushEn),
    .pushData_i(readData_q),
    .ready_i   (dac_out_tready),
    .valid_o   (dac_out_tvalid),
    .data_o    (dac_out_tdata),
    .count_o   (skidCount)
  );

endmodule

// File: tb/tb_dac_waveform_player.sv
// Directed testbench for dac_waveform_player.
// Inputs change on the falling edge; outputs are sampled on that same falling edge, so a
// beat seen with tvalid=1 and tready=1 handshakes on the following rising edge.
module tb_dac_waveform_player;

  localparam int NL = 8;
  localparam int AW = 10;
  localparam int DW = 16 * NL;

  logic          clock = 1'b0;
  logic          aresetn;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW-1:0] wrData;
  logic          start;
  logic          stop;
  logic          loopEnable;
  logic [AW-1:0] playLast;
  logic          busy;
  logic          done;
  logic [15:0]   passCount;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tready;

  int testsRun    = 0;
  int testsFailed = 0;

  // 100 MHz fabric clock.
  always #5 clock = ~clock;

  dac_waveform_player #(
    .NUMBER_OF_LINE(NL),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clock         (clock),
    .aresetn       (aresetn),
    .wr_en         (wrEn),
    .wr_addr       (wrAddr),
    .wr_data       (wrData),
    .start         (start),
    .stop          (stop),
    .loop_enable   (loopEnable),
    .play_last     (playLast),
    .busy          (busy),
    .done          (done),
    .pass_count    (passCount),
    .dac_out_tvalid(tvalid),
    .dac_out_tdata (tdata),
    .dac_out_tready(tready)
  );

  function automatic logic [DW-1:0] laneFill(input logic [15:0] v);
    return {NL{v}};
  endfunction

  task automatic loadBeat(input logic [AW-1:0] addr, input logic [15:0] v);
    @(negedge clock);
    wrEn   = 1'b1;
    wrAddr = addr;
    wrData = laneFill(v);
    @(negedge clock);
    wrEn   = 1'b0;
  endtask

  task automatic test_reset();
    aresetn    = 1'b0;
    wrEn       = 1'b0;
    wrAddr     = '0;
    wrData     = '0;
    start      = 1'b0;
    stop       = 1'b0;
    loopEnable = 1'b0;
    playLast   = '0;
    tready     = 1'b0;
    repeat (3) @(negedge clock);
    testsRun++;
    if ({busy, done, tvalid} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got busy/done/tvalid=%b expected 000", {busy, done, tvalid});
    end
    testsRun++;
    if (passCount !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_pass_count: got %0d expected 0", passCount);
    end
    testsRun++;
    if (tdata !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_tdata: got %h expected 0", tdata);
    end
    aresetn = 1'b1;
    @(negedge clock);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_idle_stop();
    int doneSeen = 0;
    @(negedge clock);
    stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      stop = 1'b0;
      if (done) doneSeen++;
      testsRun++;
      if (busy !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL idle_stop_busy: got %b expected 0", busy);
      end
    end
    testsRun++;
    if (doneSeen != 0) begin
      testsFailed++;
      $display("[TB] FAIL idle_stop_done: got %0d pulses expected 0", doneSeen);
    end
  endtask

  task automatic test_one_shot();
    int hsIter[4];
    int hsCount    = 0;
    int doneSeen   = 0;
    int firstValid = -1;
    logic [DW-1:0] beats[4];
    for (int k = 0; k < 4; k++) loadBeat(AW'(k), 16'(k + 1));
    tready     = 1'b1;
    playLast   = AW'(3);
    loopEnable = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) doneSeen++;
      if (tvalid && firstValid < 0) firstValid = i;
      if (tvalid && tready) begin
        if (hsCount < 4) begin
          hsIter[hsCount] = i;
          beats[hsCount]  = tdata;
        end
        hsCount++;
      end
    end
    testsRun++;
    if (firstValid != 3) begin
      testsFailed++;
      $display("[TB] FAIL one_shot_latency: first valid at sample %0d expected 3", firstValid);
    end
    testsRun++;
    if (hsCount != 4) begin
      testsFailed++;
      $display("[TB] FAIL one_shot_beats: got %0d beats expected 4", hsCount);
    end
    for (int k = 0; k < 4 && k < hsCount; k++) begin
      testsRun++;
      if (beats[k] !== laneFill(16'(k + 1)) || hsIter[k] != 3 + k) begin
        testsFailed++;
        $display("[TB] FAIL one_shot_beat%0d: got %h at sample %0d expected %h at sample %0d",
                 k, beats[k], hsIter[k], laneFill(16'(k + 1)), 3 + k);
      end
    end
    testsRun++;
    if (doneSeen != 1) begin
      testsFailed++;
      $display("[TB] FAIL one_shot_done: got %0d pulses expected 1", doneSeen);
    end
    testsRun++;
    if (passCount !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL one_shot_pass_count: got %0d expected 1", passCount);
    end
    testsRun++;
    if ({busy, tvalid} !== 2'b00 || tdata !== '0) begin
      testsFailed++;
      $display("[TB] FAIL one_shot_idle: got busy/tvalid=%b tdata=%h expected 00 and 0", {busy, tvalid}, tdata);
    end
  endtask

  task automatic test_loop_random();
    logic [63:0]   readyPattern = 64'hB4E1_96C3_5A2D_7F08;
    int            expIdx       = 0;
    int            passModel    = 0;
    int            hsCount      = 0;
    int            doneSeen     = 0;
    bit            prevStalled  = 1'b0;
    logic [DW-1:0] prevData     = '0;
    logic [15:0]   expVal;
    playLast   = AW'(3);
    loopEnable = 1'b1;
    tready     = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clock);
      start  = 1'b0;
      stop   = (i == 60);
      tready = readyPattern[i % 64];
      if (done) doneSeen++;
      if (prevStalled) begin
        testsRun++;
        if (tvalid !== 1'b1 || tdata !== prevData) begin
          testsFailed++;
          $display("[TB] FAIL loop_stall_hold: sample %0d got tvalid=%b tdata=%h expected 1 and %h",
                   i, tvalid, tdata, prevData);
        end
      end
      testsRun++;
      if (passCount !== 16'(passModel)) begin
        testsFailed++;
        $display("[TB] FAIL loop_pass_count: sample %0d got %0d expected %0d", i, passCount, passModel);
      end
      if (tvalid && tready) begin
        expVal = 16'(expIdx % 4 + 1);
        testsRun++;
        if (tdata !== laneFill(expVal)) begin
          testsFailed++;
          $display("[TB] FAIL loop_sequence: beat %0d got %h expected %h", expIdx, tdata, laneFill(expVal));
        end
        if (expIdx % 4 == 3) passModel++;
        expIdx++;
        hsCount++;
      end
      prevStalled = tvalid && !tready;
      prevData    = tdata;
    end
    testsRun++;
    if (hsCount <= 8) begin
      testsFailed++;
      $display("[TB] FAIL loop_progress: got %0d beats expected more than 8", hsCount);
    end
    testsRun++;
    if (doneSeen != 1 || busy !== 1'b0 || tvalid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL loop_stop_end: got done=%0d busy=%b tvalid=%b expected 1 0 0", doneSeen, busy, tvalid);
    end
  endtask

  task automatic test_stop_stall();
    int            hsCount  = 0;
    int            doneSeen = 0;
    bit            gotValid = 1'b0;
    logic [DW-1:0] held     = '0;
    tready     = 1'b0;
    playLast   = AW'(3);
    loopEnable = 1'b1;
    @(negedge clock);
    start = 1'b1;
    for (int i = 0; i < 10 && !gotValid; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (tvalid) gotValid = 1'b1;
    end
    testsRun++;
    if (!gotValid) begin
      testsFailed++;
      $display("[TB] FAIL stall_valid_timeout: got tvalid=%b expected 1 within 10 cycles", tvalid);
    end
    held = tdata;
    testsRun++;
    if (held !== laneFill(16'd1)) begin
      testsFailed++;
      $display("[TB] FAIL stall_first_beat: got %h expected %h", held, laneFill(16'd1));
    end
    stop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      stop = 1'b0;
      if (done) doneSeen++;
      testsRun++;
      if (tvalid !== 1'b1 || tdata !== held) begin
        testsFailed++;
        $display("[TB] FAIL stall_hold: got tvalid=%b tdata=%h expected 1 and %h", tvalid, tdata, held);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      tready = 1'b1;
      if (done) doneSeen++;
      if (tvalid && tready) begin
        hsCount++;
        testsRun++;
        if (tdata !== held) begin
          testsFailed++;
          $display("[TB] FAIL stall_flushed_beat: got %h expected %h", tdata, held);
        end
      end
    end
    testsRun++;
    if (hsCount != 1) begin
      testsFailed++;
      $display("[TB] FAIL stall_beat_count: got %0d expected 1", hsCount);
    end
    testsRun++;
    if (doneSeen != 1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL stall_end: got done=%0d busy=%b expected 1 0", doneSeen, busy);
    end
  endtask

  task automatic test_single_beat_loop();
    int hsModel  = 0;
    int doneSeen = 0;
    bit idleSeen = 1'b0;
    loadBeat(AW'(0), 16'hABCD);
    tready     = 1'b1;
    playLast   = AW'(0);
    loopEnable = 1'b1;
    @(negedge clock);
    start = 1'b1;
    stop  = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 1) begin
        start = 1'b0;
        stop  = 1'b0;
      end
      if (i == 12) begin
        start      = 1'b1;
        playLast   = AW'(3);
        loopEnable = 1'b0;
      end
      if (i == 13) start = 1'b0;
      testsRun++;
      if (busy !== 1'b1 || passCount !== 16'(hsModel)) begin
        testsFailed++;
        $display("[TB] FAIL single_loop_state: sample %0d got busy=%b pass=%0d expected 1 and %0d",
                 i, busy, passCount, hsModel);
      end
      if (i >= 3) begin
        testsRun++;
        if (tvalid !== 1'b1 || tdata !== laneFill(16'hABCD)) begin
          testsFailed++;
          $display("[TB] FAIL single_loop_beat: sample %0d got tvalid=%b tdata=%h expected 1 and %h",
                   i, tvalid, tdata, laneFill(16'hABCD));
        end
      end
      if (tvalid && tready) hsModel++;
    end
    @(negedge clock);
    stop = 1'b1;
    for (int i = 0; i < 10 && !idleSeen; i++) begin
      @(negedge clock);
      stop = 1'b0;
      if (done) doneSeen++;
      if (!busy) idleSeen = 1'b1;
    end
    testsRun++;
    if (!idleSeen || doneSeen != 1) begin
      testsFailed++;
      $display("[TB] FAIL single_loop_stop: got idle=%b done=%0d expected 1 and 1", idleSeen, doneSeen);
    end
  endtask

  task automatic test_async_reset();
    int            hsCount  = 0;
    int            doneSeen = 0;
    logic [15:0]   expVals[4] = '{16'hABCD, 16'd2, 16'd3, 16'd4};
    logic [DW-1:0] beats[4];
    tready     = 1'b1;
    playLast   = AW'(3);
    loopEnable = 1'b1;
    @(negedge clock);
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    testsRun++;
    if (tvalid !== 1'b1 || passCount !== 16'd1) begin
      testsFailed++;
      $display("[TB] FAIL areset_pre: got tvalid=%b pass=%0d expected 1 and 1", tvalid, passCount);
    end
    aresetn = 1'b0;
    #1;
    testsRun++;
    if ({busy, done, tvalid} !== 3'b000 || tdata !== '0 || passCount !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL areset_immediate: got busy/done/tvalid=%b tdata=%h pass=%0d expected 000 0 0",
               {busy, done, tvalid}, tdata, passCount);
    end
    @(negedge clock);
    aresetn    = 1'b1;
    loopEnable = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) doneSeen++;
      if (tvalid && tready) begin
        if (hsCount < 4) beats[hsCount] = tdata;
        hsCount++;
      end
    end
    testsRun++;
    if (hsCount != 4) begin
      testsFailed++;
      $display("[TB] FAIL areset_replay_count: got %0d beats expected 4", hsCount);
    end
    for (int k = 0; k < 4 && k < hsCount; k++) begin
      testsRun++;
      if (beats[k] !== laneFill(expVals[k])) begin
        testsFailed++;
        $display("[TB] FAIL areset_replay_beat%0d: got %h expected %h", k, beats[k], laneFill(expVals[k]));
      end
    end
    testsRun++;
    if (doneSeen != 1 || passCount !== 16'd1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL areset_replay_end: got done=%0d pass=%0d busy=%b expected 1 1 0", doneSeen, passCount, busy);
    end
  endtask

  initial begin
    test_reset();
    test_idle_stop();
    test_one_shot();
    test_loop_random();
    test_stop_stall();
    test_single_beat_loop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
